// File: rtl/lane_frames_merger.sv
// N-lane AstroPix frame merger: round-robin grant per frame onto one AXI-Stream,
// with a per-frame stall timeout and a maximum frame length guard.
module lane_frames_merger #(
    parameter int                LANES      = 4,
    parameter int                DWIDTH     = 8,
    parameter int                DESTW      = 8,
    parameter int                MAX_BEATS  = 1024,
    parameter int                TIMEOUT_W  = 16,
    parameter logic [DWIDTH-1:0] ABORT_DATA = 8'hFF,
    localparam int               GW         = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   resn,
    input  logic [LANES*DWIDTH-1:0] s_axis_tdata,
    input  logic [LANES*DESTW-1:0] s_axis_tdest,
    input  logic [LANES-1:0]       s_axis_tlast,
    input  logic [LANES-1:0]       s_axis_tvalid,
    output logic [LANES-1:0]       s_axis_tready,
    output logic [DWIDTH-1:0]      m_axis_tdata,
    output logic [DESTW-1:0]       m_axis_tdest,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic [LANES-1:0]       cfg_lane_enable,
    input  logic [TIMEOUT_W-1:0]   cfg_timeout,
    input  logic                   cfg_tdest_override,
    output logic [GW-1:0]          status_grant,
    output logic                   status_busy,
    output logic                   stat_frame_done,
    output logic                   stat_abort,
    output logic [15:0]            stat_abort_count
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {ST_ARB, ST_PASS, ST_ABORT, ST_DROP} state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [GW-1:0]         grant_r;
    logic [GW-1:0]         last_grant_r;
    logic [BW-1:0]         beat_cnt_r;
    logic [TIMEOUT_W-1:0]  stall_cnt_r;
    logic [DWIDTH-1:0]     m_tdata_r;
    logic [DESTW-1:0]      m_tdest_r;
    logic                  m_tlast_r;
    logic                  m_tvalid_r;
    logic                  frame_done_r;
    logic                  abort_r;
    logic [15:0]           abort_cnt_r;

    logic [DWIDTH-1:0]     lane_data_s [LANES];
    logic [DESTW-1:0]      lane_dest_s [LANES];
    logic [LANES-1:0]      cand_s;
    logic                  found_s;
    logic [GW-1:0]         pick_s;
    logic [GW-1:0]         idx_s;
    logic                  load_s;
    logic                  g_valid_s;
    logic                  g_last_s;
    logic [DESTW-1:0]      out_dest_s;
    logic                  accept_s;
    logic                  stall_s;
    logic                  max_beat_s;
    logic                  stall_hit_s;
    logic                  done_evt_s;
    logic                  abort_evt_s;
    logic [LANES-1:0]      ready_s;

    for (genvar g = 0; g < LANES; g++) begin : g_unpack
        assign lane_data_s[g] = s_axis_tdata[g*DWIDTH +: DWIDTH];
        assign lane_dest_s[g] = s_axis_tdest[g*DESTW +: DESTW];
    end

    assign cand_s      = s_axis_tvalid & cfg_lane_enable;
    assign load_s      = !m_tvalid_r || m_axis_tready;
    assign g_valid_s   = s_axis_tvalid[grant_r];
    assign g_last_s    = s_axis_tlast[grant_r];
    assign out_dest_s  = cfg_tdest_override ? DESTW'(grant_r) : lane_dest_s[grant_r];
    assign accept_s    = (state_r == ST_PASS) && g_valid_s && load_s;
    // Output backpressure (load low) is never counted as a lane stall.
    assign stall_s     = (state_r == ST_PASS) && !g_valid_s && load_s;
    assign max_beat_s  = (beat_cnt_r == BW'(MAX_BEATS - 1));
    assign stall_hit_s = (cfg_timeout != {TIMEOUT_W{1'b0}})
                         && ((stall_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1}) == cfg_timeout);

    // Round-robin search starting one past the last granted lane
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        for (int i = 1; i <= LANES; i++) begin
            idx_s = GW'((int'(last_grant_r) + i) % LANES);
            if (!found_s && cand_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next state, lane readiness and frame/abort events
    always_comb begin
        state_nxt_s = state_r;
        ready_s     = ~cfg_lane_enable;
        done_evt_s  = 1'b0;
        abort_evt_s = 1'b0;
        case (state_r)
            ST_ARB: begin
                if (found_s) begin
                    state_nxt_s = ST_PASS;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_PASS: begin
                ready_s[grant_r] = load_s;
                if (accept_s) begin
                    if (g_last_s) begin
                        state_nxt_s = ST_ARB;
                        done_evt_s  = 1'b1;
                    end else if (max_beat_s) begin
                        state_nxt_s = ST_DROP;
                        done_evt_s  = 1'b1;
                        abort_evt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_PASS;
                    end
                end else if (stall_s && stall_hit_s) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    state_nxt_s = ST_PASS;
                end
            end
            ST_ABORT: begin
                ready_s[grant_r] = 1'b0;
                if (load_s) begin
                    state_nxt_s = ST_DROP;
                    done_evt_s  = 1'b1;
                    abort_evt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
            ST_DROP: begin
                ready_s[grant_r] = 1'b1;
                if (!cfg_lane_enable[grant_r]) begin
                    state_nxt_s = ST_ARB;
                end else if (g_valid_s && g_last_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resn) begin
            state_r <= ST_ARB;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Grant, counters, output register and statistics
    always_ff @(posedge clk) begin
        if (!resn) begin
            grant_r      <= '0;
            last_grant_r <= GW'(LANES - 1);
            beat_cnt_r   <= '0;
            stall_cnt_r  <= '0;
            m_tdata_r    <= '0;
            m_tdest_r    <= '0;
            m_tlast_r    <= 1'b0;
            m_tvalid_r   <= 1'b0;
            frame_done_r <= 1'b0;
            abort_r      <= 1'b0;
            abort_cnt_r  <= 16'd0;
        end else begin
            frame_done_r <= done_evt_s;
            abort_r      <= abort_evt_s;
            if (abort_evt_s && (abort_cnt_r != 16'hFFFF)) begin
                abort_cnt_r <= abort_cnt_r + 16'd1;
            end
            if (load_s) begin
                m_tvalid_r <= 1'b0;
            end
            case (state_r)
                ST_ARB: begin
                    beat_cnt_r  <= '0;
                    stall_cnt_r <= '0;
                    if (found_s) begin
                        grant_r      <= pick_s;
                        last_grant_r <= pick_s;
                    end
                end
                ST_PASS: begin
                    if (accept_s) begin
                        m_tvalid_r  <= 1'b1;
                        m_tdata_r   <= lane_data_s[grant_r];
                        m_tdest_r   <= out_dest_s;
                        m_tlast_r   <= g_last_s || max_beat_s;
                        beat_cnt_r  <= beat_cnt_r + BW'(1);
                        stall_cnt_r <= '0;
                    end else if (stall_s && (stall_cnt_r != {TIMEOUT_W{1'b1}})) begin
                        stall_cnt_r <= stall_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_ABORT: begin
                    if (load_s) begin
                        m_tvalid_r <= 1'b1;
                        m_tdata_r  <= ABORT_DATA;
                        m_tdest_r  <= out_dest_s;
                        m_tlast_r  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign s_axis_tready    = resn ? ready_s : '0;
    assign m_axis_tdata     = m_tdata_r;
    assign m_axis_tdest     = m_tdest_r;
    assign m_axis_tlast     = m_tlast_r;
    assign m_axis_tvalid    = m_tvalid_r;
    assign status_grant     = grant_r;
    assign status_busy      = (state_r != ST_ARB);
    assign stat_frame_done  = frame_done_r;
    assign stat_abort       = abort_r;
    assign stat_abort_count = abort_cnt_r;

endmodule
